// File: rtl/stopwatch_ctrl.sv
// Stopwatch control FSM.
// Divides the system clock down to the count tick, turns the start/stop and
// lap/reset button levels into the datapath's enable and clear controls,
// freezes a lap value for display, and stops at 9:59.99 instead of wrapping.
//
// Button inputs are plain levels; only a rising edge (level high now, low
// on the previous cycle) has an effect. An edge acts in the cycle it is seen
// and STATE moves on the following clock edge. SW_ENABLE is a single-cycle
// strobe that the datapath samples on the same rising edge of CLK.
module stopwatch_ctrl #(
  parameter int DIV = 500000
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        START_STOP,
  input  logic        LAP_RESET,
  input  logic [19:0] TIME,
  output logic        SW_ENABLE,
  output logic        SW_RESET,
  output logic [19:0] DISPLAY,
  output logic [1:0]  STATE,
  output logic        OVF
);

  localparam int PW = $clog2(DIV);
  localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);
  localparam logic [19:0]   TIME_MAX  = 20'h95999;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_STOP = 2'd2,
    S_LAP  = 2'd3
  } state_t;

  state_t        state_q;
  state_t        state_d;
  logic [PW-1:0] presc_q;
  logic [19:0]   lap_q;
  logic          ovf_q;
  logic          ovf_d;
  logic          lap_load;
  logic          ss_q;
  logic          lr_q;

  logic ss_edge;
  logic lr_edge;
  logic running;
  logic tick;
  logic at_max;

  assign ss_edge = START_STOP & ~ss_q;
  assign lr_edge = LAP_RESET & ~lr_q;
  assign running = (state_q == S_RUN) | (state_q == S_LAP);
  assign tick    = running & (presc_q == PRESC_MAX);
  assign at_max  = (TIME == TIME_MAX);

  // Previous button levels for rising-edge detection.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      ss_q <= 1'b0;
      lr_q <= 1'b0;
    end else begin
      ss_q <= START_STOP;
      lr_q <= LAP_RESET;
    end
  end

  // Prescaler: counts while running, holds in STOP so a resume keeps the
  // partial tick, and is cleared in IDLE.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      presc_q <= '0;
    end else if (state_q == S_IDLE) begin
      presc_q <= '0;
    end else if (running) begin
      presc_q <= tick ? '0 : presc_q + PW'(1);
    end
  end

  // Lap register captures live TIME on the cycle the lap press is taken.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      lap_q <= '0;
    end else if (lap_load) begin
      lap_q <= TIME;
    end
  end

  // State and sticky overflow registers.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= S_IDLE;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ovf_q   <= ovf_d;
    end
  end

  // Next-state logic; start/stop always wins over a simultaneous lap/reset.
  always_comb begin
    state_d  = state_q;
    ovf_d    = ovf_q;
    lap_load = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ss_edge) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (ss_edge) begin
          state_d = S_STOP;
          if (tick & at_max) begin
            ovf_d = 1'b1;
          end
        end else if (lr_edge) begin
          state_d  = S_LAP;
          lap_load = 1'b1;
        end else if (tick & at_max) begin
          state_d = S_STOP;
          ovf_d   = 1'b1;
        end
      end
      S_LAP: begin
        if (ss_edge) begin
          state_d = S_STOP;
          if (tick & at_max) begin
            ovf_d = 1'b1;
          end
        end else if (lr_edge) begin
          state_d = S_RUN;
        end else if (tick & at_max) begin
          state_d = S_STOP;
          ovf_d   = 1'b1;
        end
      end
      S_STOP: begin
        if (ss_edge) begin
          // After an overflow the run cannot be resumed, only cleared.
          if (!ovf_q) begin
            state_d = S_RUN;
          end
        end else if (lr_edge) begin
          state_d = S_IDLE;
          ovf_d   = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Datapath controls and display select; reset forces the safe values
  // immediately rather than waiting for the state register.
  always_comb begin
    SW_RESET  = RESET | (state_q == S_IDLE);
    SW_ENABLE = ~RESET & tick & ~at_max;
    DISPLAY   = (~RESET & (state_q == S_LAP)) ? lap_q : TIME;
  end

  assign STATE = state_q;
  assign OVF   = ovf_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl with DIV=4: a BCD datapath model driven by the
// DUT's controls, directed scenarios, then randomized button traffic; every
// cycle the DUT outputs are compared with a behavioural model of the rules.
module tb_stopwatch_ctrl;

  localparam int DIV = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        ss;
  logic        lr;
  logic [19:0] tm = '0;
  logic        sw_en;
  logic        sw_rst;
  logic [19:0] disp;
  logic [1:0]  st;
  logic        ovf;

  logic        pre_en;
  logic [19:0] pre_val;

  int n_checks = 0;
  int n_err    = 0;
  int n_pulse  = 0;
  int n_trans  = 0;
  logic [1:0] last_st = 2'd0;

  // Reference model: mode 0 idle, 1 run, 2 stop, 3 lap; frac = clocks
  // spent running modulo DIV.
  int          m_mode = 0;
  int          m_prev_mode = 0;
  int          m_frac = 0;
  logic [19:0] m_lap = '0;
  bit          m_ovf = 0;
  bit          m_ssp = 0;
  bit          m_lrp = 0;
  logic [19:0] exp_q[$];

  stopwatch_ctrl #(.DIV(DIV)) dut (
    .CLK(clk), .RESET(rst), .START_STOP(ss), .LAP_RESET(lr), .TIME(tm),
    .SW_ENABLE(sw_en), .SW_RESET(sw_rst), .DISPLAY(disp), .STATE(st), .OVF(ovf)
  );

  // Clock.
  always #5 clk = ~clk;

  // Watchdog.
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // BCD time as a centisecond count, incremented with plain arithmetic.
  function automatic logic [19:0] bcd_inc(input logic [19:0] t);
    int n, r;
    n = t[19:16] * 6000 + t[15:12] * 1000 + t[11:8] * 100 + t[7:4] * 10 + t[3:0];
    n = (n + 1) % 60000;
    r = n % 6000;
    return {4'(n / 6000), 4'(r / 1000), 4'((r % 1000) / 100), 4'((r % 100) / 10), 4'(r % 10)};
  endfunction

  // Counter datapath fed by the DUT controls, with a bench preload port.
  always @(posedge clk) begin
    if (pre_en) tm <= pre_val;
    else if (sw_rst) tm <= '0;
    else if (sw_en) tm <= bcd_inc(tm);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: compare at the falling edge, advance the model at the rising edge.
  task automatic cycle();
    bit          run, tk, mx, ssr, lrr;
    int          nmode, nfrac;
    bit          novf;
    logic [19:0] nlap;
    @(negedge clk);
    run = (m_mode == 1) || (m_mode == 3);
    tk  = run && (m_frac == DIV - 1);
    mx  = (tm == 20'h95999);
    check("state", 32'(st), 32'(m_mode));
    check("ovf", 32'(ovf), 32'(m_ovf));
    check("sw_reset", 32'(sw_rst), 32'(rst || m_mode == 0));
    check("sw_enable", 32'(sw_en), 32'(!rst && tk && !mx));
    check("display", 32'(disp), 32'((!rst && m_mode == 3) ? m_lap : tm));
    if (!rst && m_mode == 3 && m_prev_mode != 3) begin
      check("lap_q_depth", exp_q.size(), 1);
      if (exp_q.size() > 0) check("lap_sb", 32'(disp), 32'(exp_q.pop_front()));
    end
    if (sw_en === 1'b1) n_pulse++;
    if (st !== last_st) n_trans++;
    last_st = st;

    nmode = m_mode; novf = m_ovf; nlap = m_lap;
    nfrac = (m_mode == 0) ? 0 : (run ? (m_frac + 1) % DIV : m_frac);
    ssr = ss && !m_ssp;
    lrr = lr && !m_lrp;
    if (rst) begin
      nmode = 0; nfrac = 0; novf = 0; nlap = '0; ssr = 0;
      exp_q.delete();
    end else if (m_mode == 0) begin
      if (ssr) nmode = 1;
    end else if (run) begin
      if (ssr) begin
        nmode = 2;
        if (tk && mx) novf = 1;
      end else if (lrr) begin
        if (m_mode == 1) begin
          nmode = 3; nlap = tm; exp_q.push_back(tm);
        end else begin
          nmode = 1;
        end
      end else if (tk && mx) begin
        nmode = 2; novf = 1;
      end
    end else begin
      if (ssr) begin
        if (!m_ovf) nmode = 1;
      end else if (lrr) begin
        nmode = 0; novf = 0;
      end
    end
    @(posedge clk);
    m_prev_mode = rst ? 0 : m_mode;
    m_ssp  = rst ? 0 : ss;
    m_lrp  = rst ? 0 : lr;
    m_mode = nmode; m_frac = nfrac; m_ovf = novf; m_lap = nlap;
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cycle();
  endtask

  task automatic press_ss(input int hold);
    ss = 1'b1; repeat (hold) cycle(); ss = 1'b0; cycle();
  endtask

  task automatic press_lr(input int hold);
    lr = 1'b1; repeat (hold) cycle(); lr = 1'b0; cycle();
  endtask

  task automatic preload(input logic [19:0] v);
    pre_en = 1'b1; pre_val = v; cycle(); pre_en = 1'b0;
  endtask

  task automatic run_until_time(input logic [19:0] v, input string tag);
    for (int i = 0; i < 3000 && tm != v; i++) cycle();
    check(tag, 32'(tm), 32'(v));
  endtask

  initial begin
    int p0, t0;
    logic [19:0] hold_t;
    rst = 1'b1; ss = 1'b0; lr = 1'b0; pre_en = 1'b0; pre_val = '0;
    idle(3);
    check("rst_state", 32'(st), 0);
    check("rst_swreset", 32'(sw_rst), 1);
    rst = 1'b0;
    idle(2);

    // Start, first pulse after four RUN clocks, 10 pulses reach 0.10.
    p0 = n_pulse;
    press_ss(1);
    check("run_state", 32'(st), 1);
    check("run_swreset", 32'(sw_rst), 0);
    for (int i = 0; i < 200 && (n_pulse - p0) < 10; i++) cycle();
    idle(1);
    check("ten_pulses", 32'(tm), 32'h00010);

    // Stop at 1.23, hold for 50 clocks, resume with partial prescale kept.
    run_until_time(20'h00123, "reach_123");
    press_ss(1);
    hold_t = tm;
    p0 = n_pulse;
    idle(50);
    check("stop_state", 32'(st), 2);
    check("stop_hold", 32'(tm), 32'(hold_t));
    check("stop_nopulse", n_pulse - p0, 0);
    press_ss(1);
    check("resume_state", 32'(st), 1);
    idle(20);

    // Clear, restart, lap at 0.42.
    press_ss(1);
    press_lr(1);
    check("cleared", 32'(tm), 0);
    press_ss(1);
    run_until_time(20'h00042, "reach_42");
    press_lr(1);
    idle(30);
    check("lap_state", 32'(st), 3);
    check("lap_frozen", 32'(disp), 32'h00042);
    check("lap_advance", 32'(tm > 20'h00045), 1);
    press_lr(1);
    check("lap_release", 32'(st), 1);
    check("live_disp", 32'(disp), 32'(tm));

    // Overflow stop at 9:59.99.
    press_ss(1);
    preload(20'h95998);
    press_ss(1);
    for (int i = 0; i < 100 && st != 2'd2; i++) cycle();
    idle(10);
    check("ovf_state", 32'(st), 2);
    check("ovf_flag", 32'(ovf), 1);
    check("ovf_time", 32'(tm), 32'h95999);
    press_ss(1);
    check("ovf_ss_ignored", 32'(st), 2);
    press_lr(1);
    check("ovf_clear_state", 32'(st), 0);
    check("ovf_clear_flag", 32'(ovf), 0);
    check("ovf_clear_time", 32'(tm), 0);

    // Simultaneous presses in RUN: stop, no lap.
    press_ss(1);
    idle(5);
    ss = 1'b1; lr = 1'b1; cycle(); ss = 1'b0; lr = 1'b0; cycle();
    check("both_state", 32'(st), 2);
    check("both_disp", 32'(disp), 32'(tm));

    // Held buttons give one transition each.
    t0 = n_trans;
    press_lr(20);
    check("held_lr", n_trans - t0, 1);
    t0 = n_trans;
    press_ss(20);
    check("held_ss", n_trans - t0, 1);

    // Reset in LAP mid-prescale.
    idle(5);
    press_lr(1);
    idle(2);
    p0 = n_pulse;
    rst = 1'b1; cycle(); rst = 1'b0;
    idle(5);
    check("lap_rst_state", 32'(st), 0);
    check("lap_rst_time", 32'(tm), 0);
    check("lap_rst_disp", 32'(disp), 0);
    check("lap_rst_nopulse", n_pulse - p0, 0);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      ss  = ($urandom_range(0, 5) == 0);
      lr  = ($urandom_range(0, 6) == 0);
      rst = ($urandom_range(0, 199) == 0);
      if (m_mode == 2 && !rst && $urandom_range(0, 9) == 0) begin
        pre_en  = 1'b1;
        pre_val = 20'h95990 | 20'($urandom_range(0, 9));
      end
      cycle();
      pre_en = 1'b0;
      if ($urandom_range(0, 3) == 0) begin
        ss = 1'b0; lr = 1'b0; rst = 1'b0;
        idle($urandom_range(1, 30));
      end
    end
    ss = 1'b0; lr = 1'b0; rst = 1'b0;
    idle(3);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
